// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline sequencing controller.
// Hazard terms are grouped into one struct so the detector and the FSM share a single bundle.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] PIPE_IDLE = 2'd0;
  localparam logic [1:0] PIPE_RUN  = 2'd1;
  localparam logic [1:0] PIPE_HAZ  = 2'd2;
  localparam logic [1:0] PIPE_HALT = 2'd3;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic lu;
    logic br_ex;
    logic br_ld2;
    logic br_ld1;
  } haz_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-controller bundle: stage register-use inputs and sequencing outputs.
// The master side is the datapath, the slave side is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             ctrl_branch;
  logic [REG_W-1:0] ex_wreg;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [REG_W-1:0] mem_wreg;
  logic             mem_mem_read;
  logic             step_mode;
  logic             step_req;
  logic             stall;
  logic             if_flush;
  logic             id_flush;
  logic             run_en;
  logic [1:0]       pipe_state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, ctrl_branch,
    output ex_wreg, ex_reg_write, ex_mem_read, mem_wreg, mem_mem_read, step_mode, step_req,
    input  stall, if_flush, id_flush, run_en, pipe_state, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, ctrl_branch,
    input  ex_wreg, ex_reg_write, ex_mem_read, mem_wreg, mem_mem_read, step_mode, step_req,
    output stall, if_flush, id_flush, run_en, pipe_state, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard detector: compares ID source registers against EX/MEM destinations.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_is_branch,
  input  logic [REG_W-1:0] i_ex_wreg,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_mem_wreg,
  input  logic             i_mem_mem_read,
  output haz_t             o_haz
);

  // r0 is hard-wired zero, so a match on it is never a real dependency.
  function automatic logic f_src_hit(input logic uses, input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return uses && (src != REG_W'(REG_ZERO)) && (src == dst);
  endfunction

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = f_src_hit(i_id_uses_rs, i_id_rs, i_ex_wreg) |
                       f_src_hit(i_id_uses_rt, i_id_rt, i_ex_wreg);
  assign w_mem_match = f_src_hit(i_id_uses_rs, i_id_rs, i_mem_wreg) |
                       f_src_hit(i_id_uses_rt, i_id_rt, i_mem_wreg);

  assign o_haz.lu     = i_ex_mem_read & w_ex_match;
  assign o_haz.br_ex  = i_id_is_branch & i_ex_reg_write & ~i_ex_mem_read & w_ex_match;
  assign o_haz.br_ld2 = i_id_is_branch & i_ex_mem_read & w_ex_match;
  assign o_haz.br_ld1 = i_id_is_branch & i_mem_mem_read & w_mem_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush generation, single-step debug hold,
// and a saturating hazard-stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_if.slave     bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic             r_step;
  logic [CNT_W-1:0] r_cnt;
  haz_t             w_haz;
  logic             w_any_haz;
  logic             w_step_rise;
  logic             w_stall;
  logic             w_if_flush;
  logic             w_cnt_en;

  pipe_hazard_ctrl_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .i_id_rs        (bus.id_rs),
    .i_id_rt        (bus.id_rt),
    .i_id_uses_rs   (bus.id_uses_rs),
    .i_id_uses_rt   (bus.id_uses_rt),
    .i_id_is_branch (bus.id_is_branch),
    .i_ex_wreg      (bus.ex_wreg),
    .i_ex_reg_write (bus.ex_reg_write),
    .i_ex_mem_read  (bus.ex_mem_read),
    .i_mem_wreg     (bus.mem_wreg),
    .i_mem_mem_read (bus.mem_mem_read),
    .o_haz          (w_haz)
  );

  assign w_any_haz   = |w_haz;
  assign w_step_rise = bus.step_req & ~r_step;

  always_comb begin
    w_stall    = 1'b0;
    w_if_flush = 1'b0;
    w_state_d  = r_state;
    case (r_state)
      PIPE_IDLE: w_state_d = PIPE_RUN;
      PIPE_RUN: begin
        w_stall    = w_any_haz;
        // A branch resolved on stale operands is dropped and re-evaluated after the stall.
        w_if_flush = bus.ctrl_branch & ~w_any_haz;
        if (w_haz.br_ld2)                    w_state_d = PIPE_HAZ;
        else if (bus.step_mode && !w_any_haz) w_state_d = PIPE_HALT;
      end
      PIPE_HAZ: begin
        w_stall   = 1'b1;
        w_state_d = bus.step_mode ? PIPE_HALT : PIPE_RUN;
      end
      PIPE_HALT: begin
        w_stall = 1'b1;
        if (w_step_rise || !bus.step_mode) w_state_d = PIPE_RUN;
      end
      default: w_state_d = PIPE_IDLE;
    endcase
  end

  // Debug holds in HALT are not hazards, so they are excluded from the count.
  assign w_cnt_en = w_stall & ((r_state == PIPE_RUN) | (r_state == PIPE_HAZ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PIPE_IDLE;
      r_step  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= bus.step_req;
      if (w_cnt_en && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall       = w_stall;
  assign bus.id_flush    = w_stall;
  assign bus.if_flush    = w_if_flush;
  assign bus.run_en      = (r_state != PIPE_IDLE);
  assign bus.pipe_state  = r_state;
  assign bus.stall_count = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Model state: 0 warm-up, 1 running, 2 second stall cycle, 3 debug hold.
  int   m_state;
  int   m_cnt;
  bit   m_prev_step;

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_is_branch = 0; bus.ctrl_branch = 0; bus.ex_wreg = '0; bus.ex_reg_write = 0;
    bus.ex_mem_read = 0; bus.mem_wreg = '0; bus.mem_mem_read = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_prev_step = 0;
  endtask

  function automatic bit reads(input int dst);
    return (bus.id_uses_rs && bus.id_rs != 0 && int'(bus.id_rs) == dst) ||
           (bus.id_uses_rt && bus.id_rt != 0 && int'(bus.id_rt) == dst);
  endfunction

  // Called at posedge+1: checks outputs for the current inputs, then advances one clock.
  task automatic tick(input bit do_check);
    bit lu, br_ex, br_ld2, br_ld1, haz, e_stall, e_iff;
    int nxt;
    #2;
    lu     = bus.ex_mem_read && reads(int'(bus.ex_wreg));
    br_ex  = bus.id_is_branch && bus.ex_reg_write && !bus.ex_mem_read && reads(int'(bus.ex_wreg));
    br_ld2 = bus.id_is_branch && bus.ex_mem_read && reads(int'(bus.ex_wreg));
    br_ld1 = bus.id_is_branch && bus.mem_mem_read && reads(int'(bus.mem_wreg));
    haz    = lu || br_ex || br_ld2 || br_ld1;
    e_stall = (m_state == 1) ? haz : (m_state != 0);
    e_iff   = (m_state == 1) && bus.ctrl_branch && !haz;
    if (do_check) begin
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("id_flush", 32'(bus.id_flush), 32'(e_stall));
      check("if_flush", 32'(bus.if_flush), 32'(e_iff));
      check("run_en", 32'(bus.run_en), 32'(m_state != 0));
      check("pipe_state", 32'(bus.pipe_state), 32'(m_state));
      check("stall_count", 32'(bus.stall_count), 32'(m_cnt));
    end
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (br_ld2) nxt = 2;
      else if (bus.step_mode && !haz) nxt = 3;
    end else if (m_state == 2) nxt = bus.step_mode ? 3 : 1;
    else if ((bus.step_req && !m_prev_step) || !bus.step_mode) nxt = 1;
    if (e_stall && (m_state == 1 || m_state == 2) && m_cnt < 65535) m_cnt = m_cnt + 1;
    m_prev_step = bus.step_req;
    @(posedge clk);
    m_state = nxt;
    #1;
  endtask

  initial begin
    int c0;
    int exp_states[5] = '{3, 3, 1, 3, 3};
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    clear_inputs();
    bus.step_mode = 0;
    bus.step_req  = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_state", 32'(bus.pipe_state), 0);
    check("rst_run_en", 32'(bus.run_en), 0);
    rst = 1'b0;

    // Warm-up cycle, then RUN.
    tick(1);
    check("warm_state", 32'(bus.pipe_state), 1);
    check("warm_run_en", 32'(bus.run_en), 1);

    // Load-use on r8, then the same pattern on r0.
    c0 = m_cnt;
    bus.ex_mem_read = 1; bus.ex_wreg = 8; bus.id_rs = 8; bus.id_uses_rs = 1;
    tick(1);
    clear_inputs();
    tick(1);
    check("lu_count", 32'(bus.stall_count), 32'(c0 + 1));
    bus.ex_mem_read = 1; bus.ex_wreg = 0; bus.id_rs = 0; bus.id_uses_rs = 1;
    tick(1);
    clear_inputs();
    check("r0_count", 32'(bus.stall_count), 32'(c0 + 1));

    // Branch after load: two cycles; branch after ALU producer: one cycle.
    c0 = m_cnt;
    bus.id_is_branch = 1; bus.ex_mem_read = 1; bus.ex_wreg = 3; bus.id_rt = 3; bus.id_uses_rt = 1;
    tick(1);
    check("brld2_haz", 32'(bus.pipe_state), 2);
    clear_inputs();
    tick(1);
    tick(1);
    check("brld2_count", 32'(bus.stall_count), 32'(c0 + 2));
    bus.id_is_branch = 1; bus.ex_reg_write = 1; bus.ex_wreg = 3; bus.id_rt = 3; bus.id_uses_rt = 1;
    tick(1);
    clear_inputs();
    tick(1);
    check("brex_count", 32'(bus.stall_count), 32'(c0 + 3));

    // Taken branch alone, then together with a MEM-stage load dependency.
    bus.ctrl_branch = 1;
    tick(1);
    bus.id_is_branch = 1; bus.mem_mem_read = 1; bus.mem_wreg = 5; bus.id_rs = 5; bus.id_uses_rs = 1;
    tick(1);
    clear_inputs();

    // Single step: one RUN cycle per rising edge, none while held high.
    bus.step_mode = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.step_req = 1;
      tick(1);
      check("step_state", 32'(bus.pipe_state), 32'(exp_states[i]));
    end
    bus.step_mode = 0; bus.step_req = 0;
    tick(1);
    tick(1);

    // Async reset while in the second stall cycle.
    bus.id_is_branch = 1; bus.ex_mem_read = 1; bus.ex_wreg = 3; bus.id_rs = 3; bus.id_uses_rs = 1;
    tick(1);
    clear_inputs();
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(bus.stall), 0);
    check("arst_id_flush", 32'(bus.id_flush), 0);
    check("arst_state", 32'(bus.pipe_state), 0);
    check("arst_count", 32'(bus.stall_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Saturation: continuous load-use stalls past the counter limit.
    bus.ex_mem_read = 1; bus.ex_wreg = 9; bus.id_rt = 9; bus.id_uses_rt = 1;
    for (int i = 0; i < 65540; i++) tick(0);
    check("sat_count", 32'(bus.stall_count), 32'h0000_ffff);
    tick(1);
    clear_inputs();
    tick(1);

    // Random traffic on a small register set so dependencies are frequent.
    for (int i = 0; i < 3000; i++) begin
      bus.id_rs        = 5'($urandom_range(0, 3));
      bus.id_rt        = 5'($urandom_range(0, 3));
      bus.id_uses_rs   = 1'($urandom_range(0, 1));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.id_is_branch = ($urandom_range(0, 2) == 0);
      bus.ctrl_branch  = ($urandom_range(0, 2) == 0);
      bus.ex_wreg      = 5'($urandom_range(0, 3));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_mem_read  = ($urandom_range(0, 2) == 0);
      bus.mem_wreg     = 5'($urandom_range(0, 3));
      bus.mem_mem_read = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) bus.step_mode = ~bus.step_mode;
      if ($urandom_range(0, 3) == 0) bus.step_req = ~bus.step_req;
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline.
- Observes register-use and writeback information from the ID, EX and MEM stages, together with the branch-resolution signal from ID.
- Generates the IF/PC `stall`, the IF/ID kill (`if_flush`) and the ID/EX bubble (`id_flush`).
- Provides a single-step debug mode that holds the pipeline between step requests, and exposes a hazard-stall counter for the debug display.

Parameters:
- REG_W, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_branch  in  1  ID instruction is BEQ/BNE (compares in ID)
- ctrl_branch  in  1  branch taken, resolved in ID
- ex_wreg  in  REG_W  destination register of the EX instruction
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is LW
- mem_wreg  in  REG_W  destination register of the MEM instruction
- mem_mem_read  in  1  MEM instruction is LW
- step_mode  in  1  1 = single-step debug mode
- step_req  in  1  step button, level input; rising edge = one step
- stall  out  1  hold PC and IF/ID register
- if_flush  out  1  replace the IF/ID instruction with 0
- id_flush  out  1  insert a bubble into ID/EX
- run_en  out  1  pipeline has left the warm-up state
- pipe_state  out  2  current FSM state
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async): state = IDLE, stall_count = 0, step edge register = 0. Outputs: `stall`, `if_flush`, `id_flush` and `run_en` = 0; `pipe_state` = 0.
- States:
  - IDLE = 0: one warm-up cycle after reset, covering the PC = 0xFFFFFFFF fetch; then goes to RUN.
  - RUN = 1
  - HAZ = 2: second cycle of a two-cycle stall
  - HALT = 3: step mode, waiting
- Register 0 never causes a hazard: any match on index 0 is ignored.
- Hazard terms, evaluated combinationally in the same cycle:
  - `m_rs` = id_uses_rs && id_rs != 0 && id_rs == X; `m_rt` likewise for rt. `match(X)` = m_rs || m_rt.
  - `lu` = ex_mem_read && match(ex_wreg). Load-use hazard, 1 cycle.
  - `br_ex` = id_is_branch && ex_reg_write && !ex_mem_read && match(ex_wreg). 1 cycle.
  - `br_ld2` = id_is_branch && ex_mem_read && match(ex_wreg). 2 cycles.
  - `br_ld1` = id_is_branch && mem_mem_read && match(mem_wreg). 1 cycle.
  - `haz` = lu | br_ex | br_ld2 | br_ld1.
- RUN behaviour:
  - `stall` = `id_flush` = `haz`, with zero latency, so IF samples them on the same posedge.
  - If `br_ld2`, the next state is HAZ.
  - `if_flush` = ctrl_branch && !haz. A branch resolved while its operands are stale is ignored; it is re-evaluated after the stall.
  - If step_mode = 1 and !haz, the next state is HALT; the current instruction advances.
- HAZ behaviour:
  - `stall` = `id_flush` = 1 and `if_flush` = 0.
  - Next state is RUN, or HALT if step_mode = 1.
- HALT behaviour:
  - `stall` = `id_flush` = 1 and `if_flush` = 0.
  - A registered rising edge of step_req, or step_mode dropping to 0, moves the state to RUN. That RUN cycle behaves normally, including hazards.
  - With step_mode still 1 and no hazard, the FSM returns to HALT after that one RUN cycle.
  - A hazard during a step cycle stalls normally, and the step is completed after the hazard clears.
- stall_count increments on every clock where `stall` = 1 in state RUN or HAZ. HALT cycles are not counted. The counter saturates at all-ones.
- `run_en` = 1 in every state except IDLE.
- Reset asserted mid-stall or in HALT: immediately returns to IDLE with all outputs 0, and stall_count is cleared.
- All next-state logic is registered on the rising clk edge; outputs are decoded from state plus the current inputs.

Decomposition:
- Shared package (the codebase's macro header): add `PIPE_IDLE`, `PIPE_RUN`, `PIPE_HAZ` and `PIPE_HALT` state encodings, plus the `REG_ZERO` constant.
- One sub-module is natural: `hazard_detect`, purely combinational, computing lu, br_ex, br_ld2 and br_ld1.
- The FSM, step edge detector and counter stay in the top module.

Test Plan:
- Reset release: IDLE for 1 cycle with all outputs 0, then RUN; `run_en` = 1 from the second cycle.
- Load-use: ex_mem_read = 1, ex_wreg = 8, id_rs = 8, id_uses_rs = 1 → `stall` = `id_flush` = 1 for exactly 1 cycle, stall_count = 1. Repeat with ex_wreg = id_rs = 0 → no stall.
- Branch after LW: id_is_branch = 1, ex_mem_read = 1, ex_wreg = id_rt = 3 → stall for 2 cycles (RUN then HAZ), stall_count += 2. Same case with a non-load producer (ex_reg_write only) → 1 cycle.
- Taken branch: ctrl_branch = 1 with no hazard → `if_flush` = 1 for 1 cycle and `stall` = 0. ctrl_branch = 1 together with br_ld1 → `if_flush` = 0 and `stall` = 1.
- Step mode: step_mode = 1 → HALT with `stall` = 1. Each step_req rising edge gives exactly one RUN cycle; holding step_req high gives no further advance.
- Async reset asserted during HAZ → outputs 0 immediately, state IDLE, stall_count = 0. Also drive 0xFFFF stall cycles and check stall_count holds at 0xFFFF.
